slice_serial_addsub: RTL

Parametrised multi-cycle add/subtract unit that processes a WIDTH-bit operand pair SLICE bits per clock, LSB slice first, through one carry-chained SLICE-bit adder. It replaces a full-width combinational ripple chain in the arithmetic datapath where area matters more than latency. Operands are accepted and results delivered over valid/ready handshakes. Each result carries a carry-out flag and a signed-overflow flag.

---
 rtl/slice_serial_addsub.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/slice_serial_addsub.sv
// rtl/slice_serial_addsub.sv - bit-serial-by-slice add/subtract unit with valid/ready handshakes
//
// Adds or subtracts a WIDTH-bit operand pair SLICE bits per clock, LSB slice
// first, through a single carry-chained SLICE-bit adder.
//
// Parameters:
//   WIDTH      operand/result width, an integer multiple of SLICE
//   SLICE      bits processed per clock, 1..WIDTH
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair and mode valid
//   in_ready   unit idle and able to accept an operation
//   a, b       operands
//   cin        carry in (add mode only)
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (1 = no borrow in sub mode)
//   ovf        signed overflow
module slice_serial_addsub #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  // Keep the counter at least one bit wide so NSLICE=1 still elaborates.
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0]    K_LAST     = KW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SLICE_ONES = WIDTH'({SLICE{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;      // already inverted for subtraction
  logic             carry;
  logic [KW-1:0]    k;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE-1:0] s_slice;
  logic             c_slice;
  logic             c_msb_in;
  logic             last_slice;
  logic [31:0]      shamt;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs, decoded straight from the state flops so neither
  // handshake output depends combinationally on any input.
  // ------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------------------------------
  // Slice adder
  // ------------------------------------------------------------------
  always_comb begin
    shamt      = SLICE * k;
    a_slice    = SLICE'(a_reg >> shamt);
    b_slice    = SLICE'(b_reg >> shamt);
    {c_slice, s_slice} = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry};
    // Carry into the slice MSB recovered from its sum bit: s = a ^ b ^ c_in.
    c_msb_in   = a_slice[SLICE-1] ^ b_slice[SLICE-1] ^ s_slice[SLICE-1];
    last_slice = (k == K_LAST);
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            // Subtraction is a + ~b + 1; cin is ignored in that mode.
            b_reg <= sub ? ~b : b;
            carry <= sub | cin;
            k     <= '0;
          end
        end
        RUN: begin
          sum   <= (sum & ~(SLICE_ONES << shamt)) | (WIDTH'(s_slice) << shamt);
          carry <= c_slice;
          if (last_slice) begin
            cout <= c_slice;
            ovf  <= c_msb_in ^ c_slice;
          end else begin
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
